// File: rtl/periph_resp_tracker.sv
// In-order response tracker between a crossbar speriph port and one slave peripheral.
// Optional watchdog timeout enabled by defining PERIPH_RESP_TRACKER_TIMEOUT_EN.
module periph_resp_tracker #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BE_WIDTH        = 4,
    parameter int unsigned ID_WIDTH        = 9,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 256
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 req_i,
    input  logic [ADDR_WIDTH-1:0]                add_i,
    input  logic                                 wen_i,
    input  logic [DATA_WIDTH-1:0]                wdata_i,
    input  logic [BE_WIDTH-1:0]                  be_i,
    input  logic [ID_WIDTH-1:0]                  id_i,
    output logic                                 gnt_o,
    output logic                                 r_valid_o,
    output logic [DATA_WIDTH-1:0]                r_rdata_o,
    output logic                                 r_opc_o,
    output logic [ID_WIDTH-1:0]                  r_id_o,
    output logic                                 p_req_o,
    output logic [ADDR_WIDTH-1:0]                p_add_o,
    output logic                                 p_wen_o,
    output logic [DATA_WIDTH-1:0]                p_wdata_o,
    output logic [BE_WIDTH-1:0]                  p_be_o,
    input  logic                                 p_gnt_i,
    input  logic                                 p_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                p_rdata_i,
    input  logic                                 p_err_i,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
    output logic                                 spurious_o
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ID_WIDTH-1:0]   r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_opc;
    logic [ID_WIDTH-1:0]   r_id;
    logic                  r_spurious;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_spur;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_opc;

    // Full/empty come from the registered count only: no p_rvalid_i -> gnt_o path.
    assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_empty = (r_count == '0);

    assign p_req_o   = req_i & ~w_full;
    assign gnt_o     = p_gnt_i & ~w_full;
    assign p_add_o   = add_i;
    assign p_wen_o   = wen_i;
    assign p_wdata_o = wdata_i;
    assign p_be_o    = be_i;
    assign w_push    = req_i & gnt_o;

`ifdef PERIPH_RESP_TRACKER_TIMEOUT_EN
    localparam int unsigned AGE_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [AGE_W-1:0] r_age;
    logic [CNT_W-1:0] r_drop;
    logic             w_drop_hit;
    logic             w_rsp;
    logic             w_tmo;

    // Late responses for timed-out heads arrive first (in-order) and are swallowed.
    assign w_drop_hit = p_rvalid_i & (r_drop != '0);
    assign w_rsp      = p_rvalid_i & ~w_drop_hit & ~w_empty;
    assign w_tmo      = ~w_empty & ~w_rsp & (r_age == AGE_W'(TIMEOUT_CYCLES - 1));
    assign w_pop      = w_rsp | w_tmo;
    assign w_spur     = p_rvalid_i & ~w_drop_hit & w_empty;
    assign w_rdata    = w_tmo ? DATA_WIDTH'(32'hBADACCE5) : p_rdata_i;
    assign w_opc      = w_tmo | p_err_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_age  <= '0;
            r_drop <= '0;
        end else begin
            r_age  <= (w_pop | w_empty) ? '0 : r_age + AGE_W'(1);
            r_drop <= r_drop + CNT_W'(w_tmo) - CNT_W'(w_drop_hit);
        end
    end
`else
    logic [31:0] w_unused_tmo;

    assign w_unused_tmo = TIMEOUT_CYCLES;
    assign w_pop        = p_rvalid_i & ~w_empty;
    assign w_spur       = p_rvalid_i & w_empty;
    assign w_rdata      = p_rdata_i;
    assign w_opc        = p_err_i;
`endif

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wptr] <= id_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_opc      <= 1'b0;
            r_id       <= '0;
            r_spurious <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr  <= r_rptr + PTR_W'(1);
                r_id    <= r_fifo[r_rptr];
                r_rdata <= w_rdata;
                r_opc   <= w_opc;
            end
            r_rvalid <= w_pop;
            r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_spur) begin
                r_spurious <= 1'b1;
            end
        end
    end

    assign r_valid_o     = r_rvalid;
    assign r_rdata_o     = r_rdata;
    assign r_opc_o       = r_opc;
    assign r_id_o        = r_id;
    assign outstanding_o = r_count;
    assign spurious_o    = r_spurious;

endmodule

// File: tb/tb_periph_resp_tracker.sv
// Table-driven bench with a response scoreboard for periph_resp_tracker.
// Timeout checks run only when PERIPH_RESP_TRACKER_TIMEOUT_EN is defined.
module tb_periph_resp_tracker;

    typedef struct {
        logic        req;
        logic [8:0]  id;
        logic        pgnt;
        logic        prv;
        logic [31:0] rdata;
        logic        err;
        logic        egnt;
        logic        epreq;
        logic [2:0]  ecnt;
    } vec_t;

    typedef struct {
        logic [8:0]  id;
        logic [31:0] data;
        logic        opc;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [31:0] add_i;
    logic        wen_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic [8:0]  id_i;
    logic        gnt_o;
    logic        r_valid_o;
    logic [31:0] r_rdata_o;
    logic        r_opc_o;
    logic [8:0]  r_id_o;
    logic        p_req_o;
    logic [31:0] p_add_o;
    logic        p_wen_o;
    logic [31:0] p_wdata_o;
    logic [3:0]  p_be_o;
    logic        p_gnt_i;
    logic        p_rvalid_i;
    logic [31:0] p_rdata_i;
    logic        p_err_i;
    logic [2:0]  outstanding_o;
    logic        spurious_o;

    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    logic [8:0] idq[$];
    exp_t       exp_q[$];
    vec_t       vt[25];
    exp_t       m_e;
    logic       m_due;

    periph_resp_tracker #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .BE_WIDTH       (4),
        .ID_WIDTH       (9),
        .MAX_OUTSTANDING(4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .add_i        (add_i),
        .wen_i        (wen_i),
        .wdata_i      (wdata_i),
        .be_i         (be_i),
        .id_i         (id_i),
        .gnt_o        (gnt_o),
        .r_valid_o    (r_valid_o),
        .r_rdata_o    (r_rdata_o),
        .r_opc_o      (r_opc_o),
        .r_id_o       (r_id_o),
        .p_req_o      (p_req_o),
        .p_add_o      (p_add_o),
        .p_wen_o      (p_wen_o),
        .p_wdata_o    (p_wdata_o),
        .p_be_o       (p_be_o),
        .p_gnt_i      (p_gnt_i),
        .p_rvalid_i   (p_rvalid_i),
        .p_rdata_i    (p_rdata_i),
        .p_err_i      (p_err_i),
        .outstanding_o(outstanding_o),
        .spurious_o   (spurious_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic vec_t mk(input logic req, input logic [8:0] id, input logic pgnt,
                                input logic prv, input logic [31:0] rdata, input logic err,
                                input logic egnt, input logic epreq, input logic [2:0] ecnt);
        vec_t v;
        v.req = req; v.id = id; v.pgnt = pgnt; v.prv = prv; v.rdata = rdata; v.err = err;
        v.egnt = egnt; v.epreq = epreq; v.ecnt = ecnt;
        return v;
    endfunction

    // Drive one cycle of stimulus, check the combinational outputs, update the scoreboard.
    task automatic apply(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        req_i = v.req; id_i = v.id; p_gnt_i = v.pgnt; p_rvalid_i = v.prv;
        p_rdata_i = v.rdata; p_err_i = v.err;
        add_i = $urandom; wdata_i = $urandom; wen_i = 1'($urandom); be_i = 4'($urandom);
        #1;
        chk("gnt_o", 128'(gnt_o), 128'(v.egnt));
        chk("p_req_o", 128'(p_req_o), 128'(v.epreq));
        chk("outstanding_o", 128'(outstanding_o), 128'(v.ecnt));
        chk("passthru", {p_add_o, p_wen_o, p_wdata_o, p_be_o}, {add_i, wen_i, wdata_i, be_i});
        if (v.prv && idq.size() > 0) begin
            e.id = idq.pop_front(); e.data = v.rdata; e.opc = v.err; e.due = cyc + 1;
            exp_q.push_back(e);
        end
        if (v.req && v.egnt) idq.push_back(v.id);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(mk(0, 9'h0, 0, 0, 32'h0, 0, 0, 0, outstanding_o));
    endtask

    task automatic step_quiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            req_i = 0; p_gnt_i = 0; p_rvalid_i = 0; p_err_i = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            m_due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            if (m_due || r_valid_o) begin
                chk("r_valid_o", 128'(r_valid_o), 128'(m_due));
                if (m_due) begin
                    m_e = exp_q.pop_front();
                    if (r_valid_o) begin
                        chk("r_id_o", 128'(r_id_o), 128'(m_e.id));
                        chk("r_rdata_o", 128'(r_rdata_o), 128'(m_e.data));
                        chk("r_opc_o", 128'(r_opc_o), 128'(m_e.opc));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_i = 1; req_i = 0; add_i = 0; wen_i = 1; wdata_i = 0; be_i = 0; id_i = 0;
        p_gnt_i = 0; p_rvalid_i = 0; p_rdata_i = 0; p_err_i = 0;

        vt[0]  = mk(0, 9'h000, 0, 0, 32'h0,    0, 0, 0, 0);
        vt[1]  = mk(1, 9'h004, 1, 0, 32'h0,    0, 1, 1, 0);
        vt[2]  = mk(0, 9'h000, 0, 0, 32'h0,    0, 0, 0, 1);
        vt[3]  = mk(0, 9'h000, 0, 1, 32'h1234, 0, 0, 0, 1);
        vt[4]  = mk(0, 9'h000, 0, 0, 32'h0,    0, 0, 0, 0);
        vt[5]  = mk(1, 9'h001, 1, 0, 32'h0,    0, 1, 1, 0);
        vt[6]  = mk(1, 9'h002, 1, 0, 32'h0,    0, 1, 1, 1);
        vt[7]  = mk(1, 9'h008, 1, 0, 32'h0,    0, 1, 1, 2);
        vt[8]  = mk(1, 9'h010, 1, 0, 32'h0,    0, 1, 1, 3);
        vt[9]  = mk(1, 9'h020, 1, 0, 32'h0,    0, 0, 0, 4);
        vt[10] = mk(1, 9'h020, 1, 1, 32'hAA,   0, 0, 0, 4);
        vt[11] = mk(1, 9'h020, 1, 0, 32'h0,    0, 1, 1, 3);
        vt[12] = mk(0, 9'h000, 0, 1, 32'hBB,   1, 0, 0, 4);
        vt[13] = mk(0, 9'h000, 0, 1, 32'hCC,   0, 0, 0, 3);
        vt[14] = mk(1, 9'h040, 1, 1, 32'hDD,   0, 1, 1, 2);
        vt[15] = mk(0, 9'h000, 0, 1, 32'hEE,   1, 0, 0, 2);
        vt[16] = mk(0, 9'h000, 0, 1, 32'hFF,   0, 0, 0, 1);
        vt[17] = mk(0, 9'h000, 0, 0, 32'h0,    0, 0, 0, 0);
        vt[18] = mk(1, 9'h001, 1, 0, 32'h0,    0, 1, 1, 0);
        vt[19] = mk(1, 9'h010, 1, 0, 32'h0,    0, 1, 1, 1);
        vt[20] = mk(1, 9'h100, 1, 0, 32'h0,    0, 1, 1, 2);
        vt[21] = mk(0, 9'h000, 0, 1, 32'h1,    0, 0, 0, 3);
        vt[22] = mk(0, 9'h000, 0, 1, 32'h2,    1, 0, 0, 2);
        vt[23] = mk(0, 9'h000, 0, 1, 32'h3,    0, 0, 0, 1);
        vt[24] = mk(0, 9'h000, 0, 0, 32'h0,    0, 0, 0, 0);

        // Reset state, sampled after a clock edge with reset held.
        @(posedge clk);
        #2;
        chk("rst r_valid_o", 128'(r_valid_o), 128'(0));
        chk("rst r_id_o/rdata/opc", {r_id_o, r_rdata_o, r_opc_o}, 128'(0));
        chk("rst spurious/gnt/preq", {spurious_o, gnt_o, p_req_o}, 128'(0));
        chk("rst outstanding_o", 128'(outstanding_o), 128'(0));
        @(posedge clk);
        #1;
        rst_i = 0;

        for (int i = 0; i < 25; i++) apply(vt[i]);
        idle(2);
        chk("scoreboard drained", 128'(exp_q.size()), 128'(0));

        // Spurious response: no r_valid_o, sticky flag.
        apply(mk(0, 9'h000, 0, 1, 32'h5A5A, 0, 0, 0, 0));
        step_quiet(1);
        #1;
        chk("spurious r_valid_o", 128'(r_valid_o), 128'(0));
        chk("spurious_o set", 128'(spurious_o), 128'(1));
        step_quiet(3);
        #1;
        chk("spurious_o sticky", 128'(spurious_o), 128'(1));

        // Asynchronous reset with three outstanding IDs.
        apply(mk(1, 9'h001, 1, 0, 32'h0, 0, 1, 1, 0));
        apply(mk(1, 9'h002, 1, 0, 32'h0, 0, 1, 1, 1));
        apply(mk(1, 9'h004, 1, 0, 32'h0, 0, 1, 1, 2));
        @(posedge clk);
        #1;
        req_i = 0; p_gnt_i = 0;
        #1;
        chk("outstanding before rst", 128'(outstanding_o), 128'(3));
        #1;
        rst_i = 1;
        #1;
        chk("async rst outstanding_o", 128'(outstanding_o), 128'(0));
        chk("async rst spurious_o", 128'(spurious_o), 128'(0));
        idq.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_i = 0;
        apply(mk(0, 9'h000, 0, 1, 32'h77, 0, 0, 0, 0));
        step_quiet(1);
        #1;
        chk("post-rst rvalid is spurious", {r_valid_o, spurious_o}, 128'(1));

`ifdef PERIPH_RESP_TRACKER_TIMEOUT_EN
        @(posedge clk);
        #1;
        rst_i = 1;
        @(posedge clk);
        #1;
        rst_i = 0;
        apply(mk(1, 9'h080, 1, 0, 32'h0, 0, 1, 1, 0));
        begin
            exp_t e;
            e.id = idq.pop_front(); e.data = 32'hBADACCE5; e.opc = 1'b1; e.due = cyc + 17;
            exp_q.push_back(e);
        end
        step_quiet(1);
        #1;
        chk("tmo outstanding held", 128'(outstanding_o), 128'(1));
        step_quiet(19);
        #1;
        chk("tmo outstanding cleared", 128'(outstanding_o), 128'(0));
        chk("tmo scoreboard drained", 128'(exp_q.size()), 128'(0));
        apply(mk(0, 9'h000, 0, 1, 32'h5555, 0, 0, 0, 0));
        step_quiet(1);
        #1;
        chk("late rsp dropped", {r_valid_o, spurious_o}, 128'(0));
        apply(mk(0, 9'h000, 0, 1, 32'h6666, 0, 0, 0, 0));
        step_quiet(1);
        #1;
        chk("next rsp spurious", {r_valid_o, spurious_o}, 128'(1));
`endif

        step_quiet(2);
        chk("final scoreboard empty", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
